// File: rtl/block_scan_sequencer.sv
// Block-order address sequencer: walks an N x N image in M x M blocks and issues raster addresses.
// Optional build macro STALL_CNT_EN adds stall_cnt/run_cnt performance counters.
module block_scan_sequencer #(
  parameter int ADDR_W = 20,
  parameter int SIZE_W = 10,
  parameter int LOGM_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE_W-1:0] img_size,
  input  logic [LOGM_W-1:0] blk_log2,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              blk_first,
  output logic              blk_last,
  output logic              image_done,
  output logic              busy,
  output logic              cfg_err
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       run_cnt
`endif
);

  localparam int BLK_W = 5;  // in-block coordinate, M <= 32
  localparam int SQ_W  = (2 * SIZE_W > ADDR_W + 1) ? 2 * SIZE_W : ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [BLK_W-1:0]  col, row, m_max;
  logic [SIZE_W-1:0] bcol, brow, nb_max;
  logic [ADDR_W-1:0] row_step, blk_step;

  // Config legality; the N*N check runs only at start, never per pixel.
  logic [SQ_W-1:0]   n_sq;
  logic [SIZE_W-1:0] low_mask;
  logic              cfg_ok;

  always_comb begin
    n_sq     = SQ_W'(img_size) * SQ_W'(img_size);
    low_mask = SIZE_W'((32'd1 << blk_log2) - 32'd1);
    cfg_ok   = (img_size != '0) &&
               (blk_log2 >= LOGM_W'(2)) && (blk_log2 <= LOGM_W'(5)) &&
               ((img_size & low_mask) == '0) &&
               (n_sq <= (SQ_W'(1) << ADDR_W));
  end

  logic              col_end, row_end, bcol_end, brow_end, last_px;
  logic [BLK_W-1:0]  nxt_col, nxt_row;
  logic [SIZE_W-1:0] nxt_bcol, nxt_brow;
  logic [ADDR_W-1:0] nxt_addr;

  // Incremental address step: +1 in a row, +N-M+1 at row end,
  // -(M-1)*N+1 at block end, +1 at strip end.
  always_comb begin
    col_end  = (col == m_max);
    row_end  = (row == m_max);
    bcol_end = (bcol == nb_max);
    brow_end = (brow == nb_max);
    last_px  = col_end && row_end && bcol_end && brow_end;
    nxt_col  = col;
    nxt_row  = row;
    nxt_bcol = bcol;
    nxt_brow = brow;
    nxt_addr = addr + ADDR_W'(1);
    if (!col_end) begin
      nxt_col = col + BLK_W'(1);
    end else begin
      nxt_col = '0;
      if (!row_end) begin
        nxt_row  = row + BLK_W'(1);
        nxt_addr = addr + row_step;
      end else begin
        nxt_row = '0;
        if (!bcol_end) begin
          nxt_bcol = bcol + SIZE_W'(1);
          nxt_addr = addr + blk_step;
        end else begin
          nxt_bcol = '0;
          nxt_brow = brow + SIZE_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      addr_valid <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      image_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      col        <= '0;
      row        <= '0;
      bcol       <= '0;
      brow       <= '0;
      m_max      <= '0;
      nb_max     <= '0;
      row_step   <= '0;
      blk_step   <= '0;
    end else begin
      image_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              state      <= RUN;
              addr       <= '0;
              addr_valid <= 1'b1;
              blk_first  <= 1'b1;
              blk_last   <= 1'b0;
              busy       <= 1'b1;
              col        <= '0;
              row        <= '0;
              bcol       <= '0;
              brow       <= '0;
              m_max      <= BLK_W'((32'd1 << blk_log2) - 32'd1);
              nb_max     <= (img_size >> blk_log2) - SIZE_W'(1);
              row_step   <= ADDR_W'(img_size) - ADDR_W'(32'd1 << blk_log2) + ADDR_W'(1);
              blk_step   <= ADDR_W'(1) - ((ADDR_W'(img_size) << blk_log2) - ADDR_W'(img_size));
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            addr_valid <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            busy       <= 1'b0;
          end else if (addr_valid && addr_ready) begin
            if (last_px) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              blk_first  <= 1'b0;
              blk_last   <= 1'b0;
              image_done <= 1'b1;
            end else begin
              addr      <= nxt_addr;
              col       <= nxt_col;
              row       <= nxt_row;
              bcol      <= nxt_bcol;
              brow      <= nxt_brow;
              blk_first <= (nxt_col == '0) && (nxt_row == '0);
              blk_last  <= (nxt_col == m_max) && (nxt_row == m_max);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (state == IDLE && start && !abort && cfg_ok) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (state == RUN) begin
      if (run_cnt != '1) run_cnt <= run_cnt + 32'd1;
      if (addr_valid && !addr_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_scan_sequencer.sv
// Directed self-checking bench for block_scan_sequencer; expected addresses come
// from an independent index-decomposition model plus hand-computed spot values.
module tb_block_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  img_size = '0;
  logic [2:0]  blk_log2 = '0;
  logic [19:0] addr;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        blk_first, blk_last, image_done, busy, cfg_err;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt, run_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int got [0:255];

  always #5 clk = ~clk;

  block_scan_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .img_size   (img_size),
    .blk_log2   (blk_log2),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .image_done (image_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .run_cnt    (run_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Decompose scan index k into block/pixel coordinates and form the raster address.
  function automatic int exp_addr(input int n, input int lg, input int k,
                                  output bit first, output bit last);
    int m, px, blk, nb;
    m     = 1 << lg;
    nb    = n / m;
    px    = k % (m * m);
    blk   = k / (m * m);
    first = (px == 0);
    last  = (px == m * m - 1);
    return ((blk / nb) * m + px / m) * n + (blk % nb) * m + px % m;
  endfunction

  task automatic start_image(input int n, input int lg);
    start    = 1'b1;
    img_size = 10'(n);
    blk_log2 = 3'(lg);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cfg_err", cfg_err, 0);
  endtask

  // Stream pixels until stop_at transfers; at cycle poke_at, pulse start with a
  // different config which must be ignored.
  task automatic stream(input int n, input int lg, input bit toggle,
                        input int stop_at, input int poke_at);
    int  k = 0;
    int  cyc = 0;
    bit  r, ef, el;
    int  ea;
    while (k < stop_at && cyc < 4000) begin
      ea = exp_addr(n, lg, k, ef, el);
      check("addr_valid", addr_valid, 1);
      check("addr", addr, ea);
      check("blk_first", blk_first, ef);
      check("blk_last", blk_last, el);
      check("image_done_mid", image_done, 0);
      got[k % 256] = int'(addr);
      r = toggle ? (cyc % 2 == 0) : 1'b1;
      addr_ready = r;
      if (cyc == poke_at) begin
        start    = 1'b1;
        img_size = 10'd16;
        blk_log2 = 3'd4;
      end else begin
        start = 1'b0;
      end
      if (r) k++;
      cyc++;
      @(negedge clk);
    end
    start      = 1'b0;
    addr_ready = 1'b0;
    if (k < stop_at) check("stream_timeout", k, stop_at);
  endtask

  task automatic finish_image;
    check("done_pulse", image_done, 1);
    check("done_valid", addr_valid, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("done_clear", image_done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic bad_cfg(input int n, input int lg);
    start    = 1'b1;
    img_size = 10'(n);
    blk_log2 = 3'(lg);
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    check("cfg_err_valid", addr_valid, 0);
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_err_busy2", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_first", blk_first, 0);
    check("rst_last", blk_last, 0);
    check("rst_done", image_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // N=8, M=4, always ready.
    start_image(8, 2);
    stream(8, 2, 1'b0, 64, -1);
    check("spot_17th", got[16], 4);
    check("spot_33rd", got[32], 32);
    check("spot_last", got[63], 63);
    check("spot_5th", got[4], 8);
    finish_image();
`ifdef STALL_CNT_EN
    check("run_cnt_ready", run_cnt, 64);
    check("stall_cnt_ready", stall_cnt, 0);
`endif

    // Same image with ready toggling 1/0.
    start_image(8, 2);
    stream(8, 2, 1'b1, 64, -1);
    check("tog_17th", got[16], 4);
    check("tog_last", got[63], 63);
    finish_image();
`ifdef STALL_CNT_EN
    check("run_cnt_tog", run_cnt, 127);
    check("stall_cnt_tog", stall_cnt, 63);
    @(negedge clk);
    check("run_cnt_frozen", run_cnt, 127);
`endif

    // Illegal configurations.
    bad_cfg(12, 3);
    bad_cfg(0, 2);
    bad_cfg(8, 6);
    bad_cfg(8, 1);

    // start and abort together in IDLE: abort wins.
    start    = 1'b1;
    abort    = 1'b1;
    img_size = 10'd8;
    blk_log2 = 3'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_valid", addr_valid, 0);
    check("start_abort_err", cfg_err, 0);

    // M=N: pure raster, single block.
    start_image(16, 4);
    stream(16, 4, 1'b0, 256, -1);
    check("raster_100", got[100], 100);
    check("raster_last", got[255], 255);
    finish_image();

    // Abort after 10 transfers; the transfer in the abort cycle is ignored.
    start_image(8, 2);
    stream(8, 2, 1'b0, 10, -1);
    abort      = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    addr_ready = 1'b0;
    check("abort_valid", addr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", image_done, 0);
    @(negedge clk);
    check("abort_done2", image_done, 0);
    start_image(8, 2);
    stream(8, 2, 1'b0, 64, -1);
    finish_image();

    // Reset mid-image, then restart with a start poke while busy.
    start_image(8, 2);
    stream(8, 2, 1'b0, 20, -1);
    rst        = 1'b0;
    addr_ready = 1'b1;
    @(negedge clk);
    addr_ready = 1'b0;
    check("mid_rst_addr", addr, 0);
    check("mid_rst_valid", addr_valid, 0);
    check("mid_rst_first", blk_first, 0);
    check("mid_rst_last", blk_last, 0);
    check("mid_rst_done", image_done, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", image_done, 0);
    start_image(8, 2);
    stream(8, 2, 1'b0, 64, 7);
    check("poke_17th", got[16], 4);
    finish_image();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
